fetchstage: RTL and testbench

Instruction fetch stage for the RISC-V pipeline. It feeds `inst`/`addr` pairs into the decode stage and holds them while decode asserts `stall`. It redirects on `jmp` from the branch/jump resolution logic. It drives a synchronous instruction memory with one-cycle read latency, and uses a one-entry skid buffer so that no fetched instruction is lost or duplicated under stall.

---
 rtl/fetchstage.sv | 123 ++++++++++++
 tb/tb_fetchstage.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetchstage.sv
// Instruction fetch stage: issues reads to a one-cycle synchronous instruction
// memory and presents inst/addr pairs to decode, with a one-entry skid buffer for stalls.
module fetchstage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jmp,
  input  logic [31:0] jmp_addr,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] addr,
  output logic        inst_valid
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pendAddr_q, pendAddr_d;
  logic        sv_q, sv_d;
  logic [31:0] skidInst_q, skidInst_d;
  logic [31:0] skidAddr_q, skidAddr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] addr_q, addr_d;
  logic        instValid_q, instValid_d;
  logic        run_q;
  logic        issue;
  logic        unusedBits;

  assign unusedBits = ^jmp_addr[1:0];

  // run_q keeps the first read out of the reset-release cycle, so RESET_PC is issued after E0.
  assign issue = rst_n && run_q && !jmp && !sv_q && !(stall && pend_q && instValid_q);

  assign imem_en    = issue;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign addr       = addr_q;
  assign inst_valid = instValid_q;

  always_comb begin
    pc_d        = pc_q;
    pend_d      = pend_q;
    pendAddr_d  = pendAddr_q;
    sv_d        = sv_q;
    skidInst_d  = skidInst_q;
    skidAddr_d  = skidAddr_q;
    inst_d      = inst_q;
    addr_d      = addr_q;
    instValid_d = instValid_q;

    if (jmp) begin
      pc_d        = {jmp_addr[31:2], 2'b00};
      pend_d      = 1'b0;
      sv_d        = 1'b0;
      instValid_d = 1'b0;
    end else begin
      if (issue) begin
        pend_d     = 1'b1;
        pendAddr_d = pc_q;
        pc_d       = pc_q + 32'd4;
      end else begin
        pend_d = 1'b0;
      end

      if (!stall || !instValid_q) begin
        if (sv_q) begin
          inst_d      = skidInst_q;
          addr_d      = skidAddr_q;
          instValid_d = 1'b1;
          // A response landing while the skid drains refills it, keeping order intact.
          if (pend_q) begin
            skidInst_d = imem_rdata;
            skidAddr_d = pendAddr_q;
          end else begin
            sv_d = 1'b0;
          end
        end else if (pend_q) begin
          inst_d      = imem_rdata;
          addr_d      = pendAddr_q;
          instValid_d = 1'b1;
        end else begin
          instValid_d = 1'b0;
        end
      end else if (pend_q) begin
        skidInst_d = imem_rdata;
        skidAddr_d = pendAddr_q;
        sv_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      pend_q      <= 1'b0;
      pendAddr_q  <= 32'h0;
      sv_q        <= 1'b0;
      skidInst_q  <= NOP;
      skidAddr_q  <= 32'h0;
      inst_q      <= NOP;
      addr_q      <= 32'h0;
      instValid_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pendAddr_q  <= pendAddr_d;
      sv_q        <= sv_d;
      skidInst_q  <= skidInst_d;
      skidAddr_q  <= skidAddr_d;
      inst_q      <= inst_d;
      addr_q      <= addr_d;
      instValid_q <= instValid_d;
      run_q       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetchstage.sv
// Self-checking bench for fetchstage: directed reset/stream/stall/redirect/wrap
// scenarios plus a randomized run against an in-order address-stream model.
module tb_fetchstage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n, stall, jmp;
  logic [31:0] jmp_addr;
  logic        imem_en;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] inst, addr;
  logic        inst_valid;

  logic        rst2_n;
  logic        stall2, jmp2;
  logic [31:0] jmpAddr2;
  logic        imemEn2;
  logic [31:0] imemAddr2, imemRdata2;
  logic [31:0] inst2, addr2;
  logic        instValid2;

  int checks = 0;
  int errors = 0;

  fetchstage #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .jmp(jmp), .jmp_addr(jmp_addr),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst(inst), .addr(addr), .inst_valid(inst_valid)
  );

  fetchstage #(.RESET_PC(32'hFFFF_FFF8)) dutWrap (
    .clk(clk), .rst_n(rst2_n), .stall(stall2), .jmp(jmp2), .jmp_addr(jmpAddr2),
    .imem_en(imemEn2), .imem_addr(imemAddr2), .imem_rdata(imemRdata2),
    .inst(inst2), .addr(addr2), .inst_valid(instValid2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous memories with one-cycle read latency returning addr ^ KEY.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem_addr ^ KEY;
    if (imemEn2) imemRdata2 <= imemAddr2 ^ KEY;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 1'b0; stall = 1'b0; jmp = 1'b0; jmp_addr = 32'h0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; jmp = 1'b0;
    tick(); tick();
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'h13 || addr !== 32'h0 || imem_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state got valid=%0b inst=%h addr=%h en=%0b want 0/00000013/00000000/0",
               inst_valid, inst, addr, imem_en);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (imem_en !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_issue got en=%0b imem_addr=%h valid=%0b want 1/00000100/0",
               imem_en, imem_addr, inst_valid);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL e1_valid got %0b want 0", inst_valid);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || addr !== 32'h100 || inst !== (32'h100 ^ KEY)) begin
      errors++;
      $display("[TB] FAIL first_valid got valid=%0b addr=%h inst=%h want 1/00000100/%h",
               inst_valid, addr, inst, 32'h100 ^ KEY);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    for (int i = 0; i < 10; i++) begin
      exp = 32'h100 + 32'(4 * i);
      checks++;
      if (inst_valid !== 1'b1 || addr !== exp || inst !== (exp ^ KEY)) begin
        errors++;
        $display("[TB] FAIL stream_%0d got valid=%0b addr=%h inst=%h want 1/%h/%h",
                 i, inst_valid, addr, inst, exp, exp ^ KEY);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] expSeq [2];
    int n;
    expSeq[0] = 32'h10C;
    expSeq[1] = 32'h110;
    doReset();
    tick(); tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (inst_valid !== 1'b1 || addr !== 32'h108 || inst !== (32'h108 ^ KEY)) begin
        errors++;
        $display("[TB] FAIL stall_hold_%0d got valid=%0b addr=%h want 1/00000108", k, inst_valid, addr);
      end
    end
    checks++;
    if (imem_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_skid_block got en=%0b want 0", imem_en);
    end
    stall = 1'b0;
    n = 0;
    for (int c = 0; c < 6 && n < 2; c++) begin
      tick();
      if (inst_valid === 1'b1) begin
        checks++;
        if (addr !== expSeq[n] || inst !== (expSeq[n] ^ KEY)) begin
          errors++;
          $display("[TB] FAIL stall_release_%0d got addr=%h inst=%h want %h/%h",
                   n, addr, inst, expSeq[n], expSeq[n] ^ KEY);
        end
        n++;
      end
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("[TB] FAIL stall_release_timeout got %0d outputs want 2", n);
    end
  endtask

  task automatic test_jmp();
    doReset();
    tick();
    jmp = 1'b1; jmp_addr = 32'h2003;
    tick();
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL jmp_bubble0 got valid=%0b want 0", inst_valid);
    end
    jmp = 1'b0; jmp_addr = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL jmp_bubble1 got valid=%0b want 0", inst_valid);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || addr !== 32'h2000 || inst !== (32'h2000 ^ KEY)) begin
      errors++;
      $display("[TB] FAIL jmp_target got valid=%0b addr=%h inst=%h want 1/00002000", inst_valid, addr, inst);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || addr !== 32'h2004 || inst !== (32'h2004 ^ KEY)) begin
      errors++;
      $display("[TB] FAIL jmp_next got valid=%0b addr=%h inst=%h want 1/00002004", inst_valid, addr, inst);
    end
  endtask

  task automatic test_jmp_full_skid();
    doReset();
    stall = 1'b1;
    tick(); tick();
    checks++;
    if (imem_en !== 1'b0 || addr !== 32'h100) begin
      errors++;
      $display("[TB] FAIL full_skid_setup got en=%0b addr=%h want 0/00000100", imem_en, addr);
    end
    jmp = 1'b1; jmp_addr = 32'h2003;
    tick();
    jmp = 1'b0;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_jmp_bubble0 got valid=%0b want 0", inst_valid);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_jmp_bubble1 got valid=%0b want 0", inst_valid);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || addr !== 32'h2000) begin
      errors++;
      $display("[TB] FAIL full_jmp_target got valid=%0b addr=%h want 1/00002000", inst_valid, addr);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || addr !== 32'h2000) begin
      errors++;
      $display("[TB] FAIL full_jmp_hold got valid=%0b addr=%h want 1/00002000", inst_valid, addr);
    end
    stall = 1'b0;
    tick();
    checks++;
    if (inst_valid !== 1'b1 || addr !== 32'h2004 || inst !== (32'h2004 ^ KEY)) begin
      errors++;
      $display("[TB] FAIL full_jmp_next got valid=%0b addr=%h want 1/00002004", inst_valid, addr);
    end
  endtask

  task automatic test_reset_mid_stall();
    doReset();
    stall = 1'b1;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'h13) begin
      errors++;
      $display("[TB] FAIL midreset_state got valid=%0b inst=%h want 0/00000013", inst_valid, inst);
    end
    rst_n = 1'b1; stall = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (inst_valid !== 1'b1 || addr !== 32'h100) begin
      errors++;
      $display("[TB] FAIL midreset_restart got valid=%0b addr=%h want 1/00000100", inst_valid, addr);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || addr !== 32'h104) begin
      errors++;
      $display("[TB] FAIL midreset_next got valid=%0b addr=%h want 1/00000104", inst_valid, addr);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] wrapExp [3];
    wrapExp[0] = 32'hFFFF_FFF8;
    wrapExp[1] = 32'hFFFF_FFFC;
    wrapExp[2] = 32'h0000_0000;
    rst2_n = 1'b0;
    tick(); tick();
    rst2_n = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (instValid2 !== 1'b1 || addr2 !== wrapExp[i] || inst2 !== (wrapExp[i] ^ KEY)) begin
        errors++;
        $display("[TB] FAIL wrap_%0d got valid=%0b addr=%h inst=%h want 1/%h/%h",
                 i, instValid2, addr2, inst2, wrapExp[i], wrapExp[i] ^ KEY);
      end
      tick();
    end
  endtask

  // Model: decode must consume a gap-free, in-order address stream restarting
  // at each aligned jump target, held steady while stalled, with bounded bubbles.
  task automatic test_random();
    logic [31:0] expNext, heldAddr, heldInst, target;
    logic        holdPending;
    int          idle, consumed;
    doReset();
    expNext = 32'h100;
    holdPending = 1'b0;
    idle = 0;
    consumed = 0;
    for (int c = 0; c < 600; c++) begin
      if (holdPending) begin
        checks++;
        if (inst_valid !== 1'b1 || addr !== heldAddr || inst !== heldInst) begin
          errors++;
          $display("[TB] FAIL rand_hold cyc %0d got valid=%0b addr=%h want 1/%h", c, inst_valid, addr, heldAddr);
        end
      end
      holdPending = 1'b0;
      target   = $urandom;
      stall    = ($urandom_range(0, 99) < 40);
      jmp      = ($urandom_range(0, 99) < 4);
      jmp_addr = target;
      if (jmp) begin
        expNext = {target[31:2], 2'b00};
        idle = 0;
      end else if (inst_valid === 1'b1 && !stall) begin
        checks++;
        if (addr !== expNext || inst !== (expNext ^ KEY)) begin
          errors++;
          $display("[TB] FAIL rand_order cyc %0d got addr=%h inst=%h want %h/%h",
                   c, addr, inst, expNext, expNext ^ KEY);
        end
        expNext = expNext + 32'd4;
        consumed++;
        idle = 0;
      end else if (inst_valid === 1'b1) begin
        holdPending = 1'b1;
        heldAddr = addr;
        heldInst = inst;
      end else if (!stall) begin
        idle++;
        checks++;
        if (idle > 5) begin
          errors++;
          $display("[TB] FAIL rand_progress cyc %0d got %0d idle cycles want <=5", c, idle);
          idle = 0;
        end
      end
      tick();
    end
    stall = 1'b0; jmp = 1'b0;
    checks++;
    if (consumed < 100) begin
      errors++;
      $display("[TB] FAIL rand_throughput got %0d consumed want >=100", consumed);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; jmp = 1'b0; jmp_addr = 32'h0;
    rst2_n = 1'b0; stall2 = 1'b0; jmp2 = 1'b0; jmpAddr2 = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_jmp();
    test_jmp_full_skid();
    test_reset_mid_stall();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
